// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: one req/ack bus shared by RAM and IO, store lane
// alignment, load extension and misalignment reporting. Define MEM_TIMEOUT_EN for the bus-ack timeout.
`timescale 1ns/1ps
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic        MEM_IORead,
   input  logic        MEM_IOWrite,
   input  logic        MEM_Memory_sign,
   input  logic [1:0]  MEM_Memory_data_width,
   input  logic [31:0] MEM_ALU_Result,
   input  logic [31:0] MEM_Data_In,
   input  logic        MEM_Flush,
   output logic        MEM_Stall,
   output logic [31:0] MEM_Read_Data,
   output logic        MEM_Load_Done,
   output logic        MEM_Addr_Error_Load,
   output logic        MEM_Addr_Error_Store,
   output logic [31:0] MEM_BadVAddr,
   output logic        MEM_Bus_Error,
   output logic        bus_req,
   output logic        bus_we,
   output logic        bus_io,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] REQ  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("TIMEOUT must be within 1..255");
   end

   logic [1:0]  state;
   logic [1:0]  lane;
   logic [1:0]  width_q;
   logic        sign_q;
   logic        flush_seen;
   logic        kill;
   logic        timeout_hit;
   logic        any_strobe, is_byte, is_half, misaligned;
   logic        we_n, io_n, legal_start, mis_start;
   logic [3:0]  be_n;
   logic [31:0] wdata_n, load_ext;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Space and direction are decoded independently: any IO strobe selects IO, any write strobe selects write.
   always_comb begin
      any_strobe = MEM_MemRead | MEM_MemWrite | MEM_IORead | MEM_IOWrite;
      io_n       = MEM_IORead | MEM_IOWrite;
      we_n       = MEM_IOWrite | MEM_MemWrite;
      is_byte    = (MEM_Memory_data_width == 2'b00);
      is_half    = (MEM_Memory_data_width == 2'b01);
      be_n       = 4'hF;
      wdata_n    = MEM_Data_In;
      if (is_byte) begin
         be_n    = 4'b0001 << MEM_ALU_Result[1:0];
         wdata_n = {4{MEM_Data_In[7:0]}};
      end else if (is_half) begin
         be_n    = MEM_ALU_Result[1] ? 4'b1100 : 4'b0011;
         wdata_n = {2{MEM_Data_In[15:0]}};
      end
      misaligned  = (is_half & MEM_ALU_Result[0]) |
                    (~is_byte & ~is_half & (MEM_ALU_Result[1:0] != 2'b00));
      legal_start = (state == IDLE) & any_strobe & ~MEM_Flush & ~misaligned;
      mis_start   = (state == IDLE) & any_strobe & ~MEM_Flush & misaligned;
      MEM_Stall   = legal_start | (state == REQ);
      kill        = flush_seen | MEM_Flush;
   end

   always_comb begin
      ld_byte  = bus_rdata[{lane, 3'b000} +: 8];
      ld_half  = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (width_q)
         2'b00:   load_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
         2'b01:   load_ext = {{16{sign_q & ld_half[15]}}, ld_half};
         default: load_ext = bus_rdata;
      endcase
   end

   // Handshake: bus_req rises with addr/be/wdata/we/io stable and stays high until
   // the cycle bus_ack is sampled high; bus_rdata is taken in that same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state                <= IDLE;
         bus_req              <= 1'b0;
         bus_we               <= 1'b0;
         bus_io               <= 1'b0;
         bus_addr             <= '0;
         bus_be               <= '0;
         bus_wdata            <= '0;
         lane                 <= '0;
         width_q              <= '0;
         sign_q               <= 1'b0;
         flush_seen           <= 1'b0;
         MEM_Read_Data        <= '0;
         MEM_Load_Done        <= 1'b0;
         MEM_Addr_Error_Load  <= 1'b0;
         MEM_Addr_Error_Store <= 1'b0;
         MEM_BadVAddr         <= '0;
      end else begin
         MEM_Load_Done        <= 1'b0;
         MEM_Addr_Error_Load  <= 1'b0;
         MEM_Addr_Error_Store <= 1'b0;
         case (state)
            IDLE: begin
               flush_seen <= 1'b0;
               if (legal_start) begin
                  state     <= REQ;
                  bus_req   <= 1'b1;
                  bus_we    <= we_n;
                  bus_io    <= io_n;
                  bus_addr  <= {MEM_ALU_Result[31:2], 2'b00};
                  bus_be    <= be_n;
                  bus_wdata <= wdata_n;
                  lane      <= MEM_ALU_Result[1:0];
                  width_q   <= MEM_Memory_data_width;
                  sign_q    <= MEM_Memory_sign;
               end else if (mis_start) begin
                  MEM_Addr_Error_Load  <= ~we_n;
                  MEM_Addr_Error_Store <= we_n;
                  MEM_BadVAddr         <= MEM_ALU_Result;
               end
            end
            REQ: begin
               if (MEM_Flush) flush_seen <= 1'b1;
               // A flushed access still runs to completion on the bus; only its result is dropped.
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  state   <= DONE;
                  if (!bus_we && !kill) begin
                     MEM_Read_Data <= load_ext;
                     MEM_Load_Done <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  bus_req <= 1'b0;
                  state   <= DONE;
                  if (!kill) MEM_Read_Data <= '0;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);
   logic [7:0] count;
   logic       bus_error;

   assign timeout_hit   = (count == TIMEOUT_M1);
   assign MEM_Bus_Error = bus_error;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         bus_error <= 1'b0;
      end else begin
         bus_error <= 1'b0;
         if (state == REQ) begin
            count <= count + 8'd1;
            if (!bus_ack && timeout_hit && !kill) bus_error <= 1'b1;
         end else begin
            count <= '0;
         end
      end
   end
`else
   assign timeout_hit   = 1'b0;
   assign MEM_Bus_Error = 1'b0;
`endif

   assign fsm_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drivers push hand-computed expectations into
// queues, a negedge monitor pops and compares bus requests, load results, errors and stall lengths.
`timescale 1ns/1ps
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0, MEM_IORead = 1'b0, MEM_IOWrite = 1'b0;
   logic        MEM_Memory_sign = 1'b0;
   logic [1:0]  MEM_Memory_data_width = 2'b00;
   logic [31:0] MEM_ALU_Result = '0, MEM_Data_In = '0;
   logic        MEM_Flush = 1'b0;
   logic        MEM_Stall, MEM_Load_Done, MEM_Addr_Error_Load, MEM_Addr_Error_Store, MEM_Bus_Error;
   logic [31:0] MEM_Read_Data, MEM_BadVAddr;
   logic        bus_req, bus_we, bus_io;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic [1:0]  fsm_state;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] last_rd = '0;

   logic [69:0] req_q[$];    // {we, io, be, addr, wdata}
   logic [33:0] rsp_q[$];    // {bus_error, load_done, read_data}
   logic [32:0] err_q[$];    // {is_store, badvaddr}
   logic [31:0] stall_q[$];  // stall length in cycles

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
      .MEM_IORead(MEM_IORead), .MEM_IOWrite(MEM_IOWrite),
      .MEM_Memory_sign(MEM_Memory_sign), .MEM_Memory_data_width(MEM_Memory_data_width),
      .MEM_ALU_Result(MEM_ALU_Result), .MEM_Data_In(MEM_Data_In), .MEM_Flush(MEM_Flush),
      .MEM_Stall(MEM_Stall), .MEM_Read_Data(MEM_Read_Data), .MEM_Load_Done(MEM_Load_Done),
      .MEM_Addr_Error_Load(MEM_Addr_Error_Load), .MEM_Addr_Error_Store(MEM_Addr_Error_Store),
      .MEM_BadVAddr(MEM_BadVAddr), .MEM_Bus_Error(MEM_Bus_Error),
      .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [69:0] act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got unexpected %h expected nothing", name, act);
   endtask

   // monitor / scoreboard
   logic prev_req = 1'b0;
   int   stall_run = 0;
   always @(negedge clock) begin
      if (!reset) begin
         prev_req  = 1'b0;
         stall_run = 0;
      end else begin
         if (bus_req && !prev_req) begin
            if (req_q.size() == 0) unexpected("bus_req", {bus_we, bus_io, bus_be, bus_addr, bus_wdata});
            else check("bus_req", {bus_we, bus_io, bus_be, bus_addr, bus_wdata}, req_q.pop_front());
         end
         prev_req = bus_req;
         if (MEM_Load_Done || MEM_Bus_Error) begin
            if (rsp_q.size() == 0) unexpected("load_rsp", {MEM_Bus_Error, MEM_Load_Done, MEM_Read_Data});
            else check("load_rsp", {MEM_Bus_Error, MEM_Load_Done, MEM_Read_Data}, rsp_q.pop_front());
         end
         if (MEM_Addr_Error_Load || MEM_Addr_Error_Store) begin
            if (err_q.size() == 0 || (MEM_Addr_Error_Load && MEM_Addr_Error_Store))
               unexpected("addr_err", {MEM_Addr_Error_Store, MEM_Addr_Error_Load, MEM_BadVAddr});
            else check("addr_err", {MEM_Addr_Error_Store, MEM_BadVAddr}, err_q.pop_front());
         end
         if (MEM_Stall) stall_run++;
         else if (stall_run > 0) begin
            if (stall_q.size() == 0) unexpected("stall_len", stall_run);
            else check("stall_len", stall_run, stall_q.pop_front());
            stall_run = 0;
         end
      end
   end

   // driver tasks (all called at 1ns after a rising edge)
   task automatic drive(input logic mr, mw, ir, iw, sgn, input logic [1:0] w,
                        input logic [31:0] a, d);
      MEM_MemRead = mr; MEM_MemWrite = mw; MEM_IORead = ir; MEM_IOWrite = iw;
      MEM_Memory_sign = sgn; MEM_Memory_data_width = w; MEM_ALU_Result = a; MEM_Data_In = d;
   endtask

   task automatic clear_strobes();
      MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_IORead = 1'b0; MEM_IOWrite = 1'b0;
   endtask

   task automatic bus_cycle(input int wait_c, input logic [31:0] rd, input bit flush_req);
      @(posedge clock); #1;
      if (flush_req) MEM_Flush = 1'b1;
      repeat (wait_c) begin
         @(posedge clock); #1;
         MEM_Flush = 1'b0;
      end
      bus_ack = 1'b1; bus_rdata = rd;
      @(posedge clock); #1;
      bus_ack = 1'b0; MEM_Flush = 1'b0;
      @(posedge clock); #1;
      clear_strobes();
      @(posedge clock); #1;
   endtask

   task automatic no_bus_cycle();
      @(posedge clock); #1;
      clear_strobes(); MEM_Flush = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic push_req(input logic we, io, input logic [3:0] be, input logic [31:0] a, wd);
      req_q.push_back({we, io, be, a, wd});
   endtask

   task automatic push_load(input logic [31:0] data);
      rsp_q.push_back({1'b0, 1'b1, data});
      last_rd = data;
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      check("rst_stall", MEM_Stall, 1'b0);
      check("rst_bus_req", bus_req, 1'b0);
      check("rst_bus", {bus_we, bus_io, bus_be, bus_addr}, '0);
      check("rst_data", {MEM_Read_Data, MEM_BadVAddr}, '0);
      check("rst_state", fsm_state, 2'b00);
      reset = 1'b1;
      @(posedge clock); #1;

      // word load, three wait cycles
      push_req(0, 0, 4'hF, 32'h104, 32'h0); push_load(32'hDEADBEEF); stall_q.push_back(5);
      drive(1, 0, 0, 0, 0, 2'b10, 32'h104, 32'h0);
      bus_cycle(3, 32'hDEADBEEF, 0);

      // signed and unsigned byte load, lane 3
      push_req(0, 0, 4'b1000, 32'h200, 32'h0); push_load(32'hFFFFFF80); stall_q.push_back(2);
      drive(1, 0, 0, 0, 1, 2'b00, 32'h203, 32'h0);
      bus_cycle(0, 32'h80123456, 0);
      push_req(0, 0, 4'b1000, 32'h200, 32'h0); push_load(32'h00000080); stall_q.push_back(2);
      drive(1, 0, 0, 0, 0, 2'b00, 32'h203, 32'h0);
      bus_cycle(0, 32'h80123456, 0);

      // half store, upper lane
      push_req(1, 0, 4'b1100, 32'h10, 32'hABCDABCD); stall_q.push_back(2);
      drive(0, 1, 0, 0, 0, 2'b01, 32'h12, 32'h0000ABCD);
      bus_cycle(0, 32'h0, 0);

      // misaligned word load and half store
      err_q.push_back({1'b0, 32'h00000006});
      drive(1, 0, 0, 0, 0, 2'b10, 32'h6, 32'h0);
      #1 check("mis_no_stall", MEM_Stall, 1'b0);
      no_bus_cycle();
      err_q.push_back({1'b1, 32'h00001001});
      drive(0, 1, 0, 0, 0, 2'b01, 32'h1001, 32'h5555);
      no_bus_cycle();

      // IO read + mem write -> IO write; flush during REQ
      push_req(1, 1, 4'hF, 32'hFFFFFC60, 32'h12345678); stall_q.push_back(3);
      drive(0, 1, 1, 0, 0, 2'b10, 32'hFFFFFC60, 32'h12345678);
      bus_cycle(1, 32'h0, 1);

      // half loads: signed upper lane, unsigned lower lane
      push_req(0, 0, 4'b1100, 32'h20, 32'h0); push_load(32'hFFFF8001); stall_q.push_back(2);
      drive(1, 0, 0, 0, 1, 2'b01, 32'h22, 32'h0);
      bus_cycle(0, 32'h80017FFF, 0);
      push_req(0, 0, 4'b0011, 32'h20, 32'h0); push_load(32'h0000F00D); stall_q.push_back(3);
      drive(1, 0, 0, 0, 0, 2'b01, 32'h20, 32'h0);
      bus_cycle(1, 32'h8001F00D, 0);

      // byte store lane 1
      push_req(1, 0, 4'b0010, 32'h30, 32'hA5A5A5A5); stall_q.push_back(2);
      drive(0, 1, 0, 0, 0, 2'b00, 32'h31, 32'h000000A5);
      bus_cycle(0, 32'h0, 0);

      // IO load with width 11 treated as word, sign ignored
      push_req(0, 1, 4'hF, 32'h44, 32'h0); push_load(32'h87654321); stall_q.push_back(2);
      drive(0, 0, 1, 0, 1, 2'b11, 32'h44, 32'h0);
      bus_cycle(0, 32'h87654321, 0);

      // signed byte load with positive value, lane 1
      push_req(0, 0, 4'b0010, 32'h40, 32'h0); push_load(32'h0000007F); stall_q.push_back(2);
      drive(1, 0, 0, 0, 1, 2'b00, 32'h41, 32'h0);
      bus_cycle(0, 32'h00007F00, 0);

      // flushed load: bus completes, result dropped
      push_req(0, 0, 4'hF, 32'h50, 32'h0); stall_q.push_back(3);
      drive(1, 0, 0, 0, 0, 2'b10, 32'h50, 32'h0);
      bus_cycle(1, 32'h11111111, 1);
      check("flush_hold_data", MEM_Read_Data, last_rd);

      // flush in IDLE ignores legal and misaligned strobes
      MEM_Flush = 1'b1;
      drive(1, 0, 0, 0, 0, 2'b10, 32'h60, 32'h0);
      #1 check("flush_idle_stall", MEM_Stall, 1'b0);
      no_bus_cycle();
      MEM_Flush = 1'b1;
      drive(1, 0, 0, 0, 0, 2'b10, 32'h62, 32'h0);
      no_bus_cycle();

`ifdef MEM_TIMEOUT_EN
      // no ack: request held TO cycles, then bus error with zeroed data
      push_req(0, 0, 4'hF, 32'h80, 32'h0); rsp_q.push_back({1'b1, 1'b0, 32'h0});
      last_rd = 32'h0; stall_q.push_back(TO + 1);
      drive(1, 0, 0, 0, 0, 2'b10, 32'h80, 32'h0);
      repeat (TO + 1) @(posedge clock);
      #1 check("timeout_req_drop", bus_req, 1'b0);
      @(posedge clock); #1;
      clear_strobes();
      check("timeout_idle", fsm_state, 2'b00);
      @(posedge clock); #1;
`endif

      // async reset in the middle of REQ
      push_req(0, 0, 4'hF, 32'h70, 32'h0);
      drive(1, 0, 0, 0, 0, 2'b10, 32'h70, 32'h0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0; clear_strobes();
      #1;
      check("midrst_bus_req", bus_req, 1'b0);
      check("midrst_stall", MEM_Stall, 1'b0);
      check("midrst_state", fsm_state, 2'b00);
      check("midrst_data", MEM_Read_Data, 32'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;

      check("req_q_drained", req_q.size(), 0);
      check("rsp_q_drained", rsp_q.size(), 0);
      check("err_q_drained", err_q.size(), 0);
      check("stall_q_drained", stall_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-access controller; consumes the EX/MEM pipeline register outputs (MEM_MemRead/Write, MEM_IORead/Write, width, sign, address, store data).
- Drives a single req/ack data bus shared by data RAM and IO space, with a stall to the pipeline while an access is in flight.
- Performs store byte-lane alignment, load extraction/extension and misalignment detection, reported to CP0 logic.

Parameters:
- TIMEOUT, 255, max cycles to wait for bus_ack before abort (range 1..255, 8-bit counter).

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- MEM_MemRead  in  1  memory load strobe.
- MEM_MemWrite  in  1  memory store strobe.
- MEM_IORead  in  1  IO load strobe.
- MEM_IOWrite  in  1  IO store strobe.
- MEM_Memory_sign  in  1  1 = sign-extend load.
- MEM_Memory_data_width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- MEM_ALU_Result  in  32  effective address.
- MEM_Data_In  in  32  store data (rt value).
- MEM_Flush  in  1  exception flush of the instruction in MEM.
- MEM_Stall  out  1  hold IF..EX/MEM registers.
- MEM_Read_Data  out  32  extended load result, registered.
- MEM_Load_Done  out  1  one-cycle pulse, MEM_Read_Data valid.
- MEM_Addr_Error_Load  out  1  one-cycle pulse, misaligned load.
- MEM_Addr_Error_Store  out  1  one-cycle pulse, misaligned store.
- MEM_BadVAddr  out  32  faulting address, held until next error.
- MEM_Bus_Error  out  1  one-cycle pulse on timeout.
- bus_req  out  1  request, held until ack.
- bus_we  out  1  1 = write.
- bus_io  out  1  1 = IO space.
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- bus_be  out  4  byte enables, little-endian.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transfer complete; rdata valid same cycle.
- bus_rdata  in  32  read data.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; counter 0. Reset mid-access drops bus_req immediately; result discarded.
- Strobe priority: IO over Mem; Write over Read. Any strobe with MEM_Flush=1 in IDLE is ignored.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0 → no bus access, no stall. Next edge: pulse Addr_Error_Load/Store; BadVAddr<=addr.
- FSM IDLE: legal strobe → MEM_Stall=1 combinationally. Next edge: → REQ and latch bus_addr/be/wdata/we/io, lane and extension info; bus_req<=1.
- FSM REQ: MEM_Stall=1; counter increments.
  - bus_ack=1 → bus_req<=0; if load, capture extended rdata into MEM_Read_Data; → DONE.
  - With MEM_TIMEOUT_EN: counter==TIMEOUT-1 without ack → bus_req<=0, MEM_Read_Data<=0, Bus_Error set; → DONE.
- FSM DONE: MEM_Stall=0; Load_Done/Bus_Error high this cycle only; unconditional → IDLE. The held strobes do not relaunch.
- Minimum latency: strobe at cycle 0 IDLE, ack in first REQ cycle → data and Load_Done at cycle 2; stall for 2 cycles.
- MEM_Flush during REQ: bus transaction completes (never aborted); Load_Done and Bus_Error suppressed; MEM_Read_Data unchanged.
- Store lanes:
  - byte: wdata={4{d[7:0]}}, be=0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, be=addr[1]?1100:0011.
  - word: be=1111.
- Load: select lane by latched addr[1:0]; sign/zero-extend to 32 per MEM_Memory_sign; word ignores sign.

Optional Feature:
- MEM_TIMEOUT_EN defined: timeout counter and MEM_Bus_Error active as above.
- Undefined: no counter; REQ waits indefinitely for bus_ack; MEM_Bus_Error tied 0.

Test Plan:
- Word load addr 0x00000104, sign=0, ack after 3 wait cycles, rdata 0xDEADBEEF → bus_be=1111, bus_addr 0x104, stall 5 cycles, Read_Data=0xDEADBEEF with Load_Done pulse.
- Signed byte load addr 0x00000203, rdata 0x80123456 → be=1000, Read_Data=0xFFFFFF80. Same with sign=0 → 0x00000080.
- Half store addr 0x00000012, Data_In 0x0000ABCD, ack immediate → bus_we=1, be=1100, wdata=0xABCDABCD, stall 2 cycles, no Load_Done.
- Word load addr 0x00000006 → no bus_req, no stall, Addr_Error_Load pulse, BadVAddr=0x00000006; half store addr 0x1001 → Addr_Error_Store.
- IORead and MemWrite both high, addr 0xFFFFFC60 → bus_io=1, bus_we=1; Flush asserted during REQ → access completes, no Load_Done.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack → bus_req high 4 cycles then drops; Bus_Error pulse, Read_Data=0, returns IDLE. Async reset asserted mid-REQ → bus_req=0 immediately.
